matram_lane_sequencer: RTL and testbench
========================================

Name: matram_lane_sequencer

Overview:
- Multi-lane address sequencer for the MatRAM banks feeding the Matrix Acceleration Unit (MAU).
- Holds one base address per lane. On mau_start it walks all lanes in lock-step through a strided burst of programmable length.
- Inserts a programmable sync bubble after the first beat and honours a stall from the MAU datapath.
- Raises a done pulse at burst end.

Parameters:
- LANES, 4, number of MatRAM lanes driven.
- ADDR_W, 10, address width per lane.
- LEN_W, 4, burst length field width (max burst 2^LEN_W-1 beats).
- SYNC_CYCLES, 1, bubble cycles inserted after beat 0 (0 = no bubble).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- set_address  in  1  write address_in into base register of lane_sel.
- lane_sel  in  $clog2(LANES)  target lane for set_address.
- address_in  in  ADDR_W  base address to load.
- stride  in  ADDR_W  per-beat address increment, latched at start.
- burst_len  in  LEN_W  beats in burst, latched at start.
- mau_start  in  1  start request.
- stall  in  1  MAU not ready; current beat held.
- address_out  out  LANES*ADDR_W  lane l at bits [l*ADDR_W +: ADDR_W] = base[l] + offset.
- addr_valid  out  1  address_out is a live beat.
- busy  out  1  high in ACTIVE or SYNC.
- done  out  1  one-cycle pulse after last beat accepted.

Behaviour:
- Reset (reset_n low, any state): state=IDLE, all base regs=0, offset=0, beat count=0, bubble count=0, latched stride/len=0. Outputs: address_out=0, addr_valid=0, busy=0, done=0.
- address_out is combinational from registers: base[l] + offset, modulo 2^ADDR_W (wraps silently, no carry out). Valid in every state; in IDLE offset=0.
- Beat accepted = clock edge with addr_valid=1 and stall=0.
- IDLE:
  - set_address loads base[lane_sel].
  - mau_start with burst_len!=0: latch stride and burst_len, offset=0, beat=0, next state ACTIVE.
  - mau_start with burst_len==0: stay IDLE, done=1 next cycle, no beats.
  - set_address and mau_start in the same cycle: the base write takes effect first. The burst uses the new base from its first beat.
- ACTIVE:
  - addr_valid=1.
  - On accept, offset += stride and beat += 1.
  - If the accepted beat was the last (beat == len-1): next state IDLE, offset=0, done=1 for one cycle.
  - Else if the accepted beat was beat 0 and SYNC_CYCLES>0: next state SYNC, bubble=SYNC_CYCLES-1.
  - Stall holds state, offset and beat unchanged.
- SYNC:
  - addr_valid=0; address_out already shows beat 1.
  - Counts the bubble down regardless of stall; at 0 returns to ACTIVE.
  - With len==1, beat 0 is the last beat, so no SYNC is entered.
- Ignored inputs:
  - set_address outside IDLE is ignored (bases frozen during a burst).
  - mau_start outside IDLE is ignored.
  - stride and burst_len changes mid-burst have no effect.
- Latency:
  - mau_start at edge T: beat 0 valid in cycle T+1.
  - Unstalled total = len + SYNC_CYCLES (len>1) cycles of busy.
  - done asserts in the cycle after the last accept; busy is low in that cycle.
- Reset mid-burst: immediate return to reset values, base regs included. No done pulse is issued.

Decomposition:
- Package matram_pkg:
  - state enum {IDLE, ACTIVE, SYNC}, 2-bit encoded.
  - Default ADDR_W and LEN_W localparams.
  - Function lane_slice(l) returning the bit offset l*ADDR_W.
- Sub-module matram_base_regfile: LANES x ADDR_W write-enabled register file with async active-low clear, write port (set_address, lane_sel, address_in) and flat read bus. The sequencer top holds the FSM, offset accumulator and counters.

Test Plan:
- Load bases 0x000/0x100/0x200/0x300 via set_address, stride=1, burst_len=4, SYNC_CYCLES=1, start -> lane0 beats 0x000,(bubble),0x001,0x002,0x003; lane3 0x300..0x303; busy 5 cycles; done one cycle after last beat.
- Base 0x3FE, stride=3, len=3, no stall -> lane addresses 0x3FE, 0x001, 0x004 (wrap mod 1024).
- stall high for 2 cycles on beat 2 of len=4 -> address_out holds beat-2 value for 3 cycles; total busy +2; done still single pulse.
- burst_len=0 with mau_start -> addr_valid never high, busy stays 0, done=1 the next cycle.
- mau_start and set_address(lane1, 0x050) during ACTIVE -> no restart, lane1 base unchanged until IDLE; subsequent set_address in IDLE takes effect.
- reset_n pulsed low in SYNC of a len=4 burst -> all outputs 0 asynchronously, no done; new start after release runs from base 0.

Source files
------------

// File: rtl/matram_pkg.sv
// Shared types and defaults for the MatRAM lane sequencer and its base register file.
package matram_pkg;

  localparam int MATRAM_ADDR_W = 10;
  localparam int MATRAM_LEN_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    SYNC   = 2'd2
  } state_e;

  // Bit position of lane l inside a flat LANES*addr_w bus.
  function automatic int lane_slice(input int l, input int addr_w = MATRAM_ADDR_W);
    return l * addr_w;
  endfunction

endpackage

// File: rtl/matram_base_regfile.sv
// Per-lane base address registers: one write port, flat read bus of all lanes.
module matram_base_regfile
  import matram_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int ADDR_W = MATRAM_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_we,
  input  logic [$clog2(LANES)-1:0]  i_sel,
  input  logic [ADDR_W-1:0]         i_wdata,
  output logic [LANES*ADDR_W-1:0]   o_base_flat
);

  logic [ADDR_W-1:0] r_base [LANES];

  // NOTE: this array is small and must read as zero after reset, so every entry is
  // cleared; a large RAM-style array would normally be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < LANES; l++) r_base[l] <= '0;
    end else if (i_we) begin
      for (int l = 0; l < LANES; l++) begin
        if (i_sel == ($clog2(LANES))'(l)) r_base[l] <= i_wdata;
      end
    end
  end

  always_comb begin
    o_base_flat = '0;
    for (int l = 0; l < LANES; l++) o_base_flat[lane_slice(l, ADDR_W) +: ADDR_W] = r_base[l];
  end

endmodule

// File: rtl/matram_lane_sequencer.sv
// Lock-step strided burst sequencer for the MatRAM lanes feeding the MAU, with a
// sync bubble after beat 0, stall hold and an end-of-burst done pulse.
module matram_lane_sequencer
  import matram_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int ADDR_W      = MATRAM_ADDR_W,
  parameter int LEN_W       = MATRAM_LEN_W,
  parameter int SYNC_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      set_address,
  input  logic [$clog2(LANES)-1:0]  lane_sel,
  input  logic [ADDR_W-1:0]         address_in,
  input  logic [ADDR_W-1:0]         stride,
  input  logic [LEN_W-1:0]          burst_len,
  input  logic                      mau_start,
  input  logic                      stall,
  output logic [LANES*ADDR_W-1:0]   address_out,
  output logic                      addr_valid,
  output logic                      busy,
  output logic                      done
);

  localparam int BUB_W = (SYNC_CYCLES > 2) ? $clog2(SYNC_CYCLES) : 1;

  state_e                   r_state;
  state_e                   w_next_state;
  logic [ADDR_W-1:0]        r_offset;
  logic [ADDR_W-1:0]        r_stride;
  logic [LEN_W-1:0]         r_len;
  logic [LEN_W-1:0]         r_beat;
  logic [BUB_W-1:0]         r_bubble;
  logic                     r_done;
  logic [LANES*ADDR_W-1:0]  w_base_flat;
  logic                     w_start;
  logic                     w_start_burst;
  logic                     w_accept;
  logic                     w_last;
  logic                     w_enter_sync;

  // Bases are frozen during a burst; a write in the start cycle lands before beat 0.
  matram_base_regfile #(
    .LANES  (LANES),
    .ADDR_W (ADDR_W)
  ) u_base_regfile (
    .clk         (clk),
    .rst_n       (reset_n),
    .i_we        (set_address && (r_state == IDLE)),
    .i_sel       (lane_sel),
    .i_wdata     (address_in),
    .o_base_flat (w_base_flat)
  );

  assign w_start       = (r_state == IDLE) && mau_start;
  assign w_start_burst = w_start && (burst_len != '0);
  assign w_accept      = (r_state == ACTIVE) && !stall;
  assign w_last        = w_accept && (r_beat == r_len - LEN_W'(1));
  assign w_enter_sync  = w_accept && !w_last && (r_beat == '0) && (SYNC_CYCLES > 0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // NOTE: default assignment first so every path assigns w_next_state and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_start_burst) w_next_state = ACTIVE;
      ACTIVE: begin
        if (w_last)            w_next_state = IDLE;
        else if (w_enter_sync) w_next_state = SYNC;
      end
      SYNC:    if (r_bubble == '0) w_next_state = ACTIVE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    addr_valid = (r_state == ACTIVE);
    busy       = (r_state != IDLE);
    done       = r_done;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_offset <= '0;
      r_stride <= '0;
      r_len    <= '0;
      r_beat   <= '0;
      r_bubble <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (w_start && (burst_len == '0)) || w_last;
      if (w_start_burst) begin
        r_stride <= stride;
        r_len    <= burst_len;
        r_offset <= '0;
        r_beat   <= '0;
      end else if (w_last) begin
        r_offset <= '0;
        r_beat   <= '0;
      end else if (w_accept) begin
        r_offset <= r_offset + r_stride;
        r_beat   <= r_beat + LEN_W'(1);
      end
      // The bubble runs off the clock alone; stall does not extend it.
      if (w_enter_sync)                                  r_bubble <= BUB_W'(SYNC_CYCLES - 1);
      else if ((r_state == SYNC) && (r_bubble != '0))    r_bubble <= r_bubble - BUB_W'(1);
    end
  end

  // Lane addresses wrap modulo 2^ADDR_W; the carry is dropped by the sized sum.
  always_comb begin
    address_out = '0;
    for (int l = 0; l < LANES; l++) begin
      address_out[lane_slice(l, ADDR_W) +: ADDR_W] =
        w_base_flat[lane_slice(l, ADDR_W) +: ADDR_W] + r_offset;
    end
  end

endmodule

// File: tb/tb_matram_lane_sequencer.sv
// Directed bench for matram_lane_sequencer: a scoreboard queue of expected lane
// address buses is popped on every accepted beat, plus directed status checks.
module tb_matram_lane_sequencer;

  localparam int LANES  = 4;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 4;
  localparam int BUS_W  = LANES * ADDR_W;

  logic              clk;
  logic              reset_n;
  logic              set_address;
  logic [1:0]        lane_sel;
  logic [ADDR_W-1:0] address_in;
  logic [ADDR_W-1:0] stride;
  logic [LEN_W-1:0]  burst_len;
  logic              mau_start;
  logic              stall;
  logic [BUS_W-1:0]  address_out;
  logic              addr_valid;
  logic              busy;
  logic              done;

  matram_lane_sequencer #(
    .LANES       (LANES),
    .ADDR_W      (ADDR_W),
    .LEN_W       (LEN_W),
    .SYNC_CYCLES (1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .set_address (set_address),
    .lane_sel    (lane_sel),
    .address_in  (address_in),
    .stride      (stride),
    .burst_len   (burst_len),
    .mau_start   (mau_start),
    .stall       (stall),
    .address_out (address_out),
    .addr_valid  (addr_valid),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  logic [ADDR_W-1:0] mb [LANES];
  logic [BUS_W-1:0]  exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [BUS_W-1:0] exp_bus(input int beat, input logic [ADDR_W-1:0] strd);
    logic [ADDR_W-1:0] off;
    logic [BUS_W-1:0]  v;
    off = '0;
    for (int i = 0; i < beat; i++) off = off + strd;
    for (int l = 0; l < LANES; l++) v[l*ADDR_W +: ADDR_W] = mb[l] + off;
    return v;
  endfunction

  // Monitor: every accepted beat must match the scoreboard head.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      check("done_with_busy_low", {63'd0, busy}, 64'd0);
    end
    if (addr_valid && !stall) begin
      if (exp_q.size() == 0) check("unexpected_beat", address_out, 64'hDEAD);
      else                   check("beat_address", address_out, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_base(input int l, input logic [ADDR_W-1:0] a);
    set_address = 1'b1;
    lane_sel    = 2'(l);
    address_in  = a;
    mb[l]       = a;
    step();
    set_address = 1'b0;
  endtask

  task automatic push_burst(input logic [ADDR_W-1:0] strd, input int len);
    for (int b = 0; b < len; b++) exp_q.push_back(exp_bus(b, strd));
  endtask

  task automatic start(input logic [ADDR_W-1:0] strd, input int len);
    push_burst(strd, len);
    stride    = strd;
    burst_len = LEN_W'(len);
    mau_start = 1'b1;
    step();
    mau_start = 1'b0;
    stride    = 10'h3FF;
    burst_len = 4'hF;
  endtask

  task automatic wait_done(input string tag);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 60; i++) begin
      if (done_cnt != d0) break;
      step();
    end
    step();
    step();
    check({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    reset_n     = 1'b0;
    set_address = 1'b0;
    lane_sel    = '0;
    address_in  = '0;
    stride      = '0;
    burst_len   = '0;
    mau_start   = 1'b0;
    stall       = 1'b0;
    for (int l = 0; l < LANES; l++) mb[l] = '0;
    step();
    step();
    check("reset_address_out", address_out, 64'd0);
    check("reset_valid_busy_done", {61'd0, addr_valid, busy, done}, 64'd0);
    reset_n = 1'b1;
    step();

    // 1: four lanes, stride 1, len 4, one bubble after beat 0.
    set_base(0, 10'h000);
    set_base(1, 10'h100);
    set_base(2, 10'h200);
    set_base(3, 10'h300);
    busy_cnt = 0;
    start(10'd1, 4);
    check("t1_beat0_valid_busy", {62'd0, addr_valid, busy}, 64'd3);
    check("t1_beat0_lane3", 64'(address_out[3*ADDR_W +: ADDR_W]), 64'h300);
    step();
    check("t1_sync_valid_busy", {62'd0, addr_valid, busy}, 64'd1);
    check("t1_sync_shows_beat1", address_out, exp_bus(1, 10'd1));
    wait_done("t1");
    check("t1_busy_cycles", 64'(busy_cnt), 64'd5);

    // 2: wrap modulo 1024 on lane 0.
    set_base(0, 10'h3FE);
    busy_cnt = 0;
    start(10'd3, 3);
    step();
    step();
    check("t2_lane0_beat1_wrap", 64'(address_out[0 +: ADDR_W]), 64'h001);
    wait_done("t2");
    check("t2_busy_cycles", 64'(busy_cnt), 64'd4);

    // 3: two-cycle stall on beat 2 of a len=4 burst.
    busy_cnt = 0;
    start(10'd1, 4);
    step();
    step();
    step();
    stall = 1'b1;
    check("t3_hold_c0", address_out, exp_bus(2, 10'd1));
    step();
    check("t3_hold_c1", address_out, exp_bus(2, 10'd1));
    step();
    stall = 1'b0;
    check("t3_hold_c2", address_out, exp_bus(2, 10'd1));
    check("t3_valid_after_stall", {63'd0, addr_valid}, 64'd1);
    wait_done("t3");
    check("t3_busy_cycles", 64'(busy_cnt), 64'd7);

    // 4: zero-length start only pulses done.
    busy_cnt = 0;
    start(10'd1, 0);
    check("t4_done_next_cycle", {61'd0, done, busy, addr_valid}, 64'd4);
    step();
    check("t4_done_single", {63'd0, done}, 64'd0);
    check("t4_busy_cycles", 64'(busy_cnt), 64'd0);

    // 5: start and base write during ACTIVE are ignored.
    busy_cnt = 0;
    start(10'd1, 4);
    mau_start   = 1'b1;
    burst_len   = 4'd2;
    set_address = 1'b1;
    lane_sel    = 2'd1;
    address_in  = 10'h050;
    step();
    mau_start   = 1'b0;
    set_address = 1'b0;
    wait_done("t5");
    check("t5_busy_no_restart", 64'(busy_cnt), 64'd5);
    check("t5_lane1_base_kept", 64'(address_out[1*ADDR_W +: ADDR_W]), 64'(mb[1]));
    set_base(1, 10'h050);
    check("t5_lane1_idle_write", 64'(address_out[1*ADDR_W +: ADDR_W]), 64'h050);

    // 5b: base write and start in the same idle cycle; burst sees new base.
    set_address = 1'b1;
    lane_sel    = 2'd2;
    address_in  = 10'h2AA;
    mb[2]       = 10'h2AA;
    busy_cnt    = 0;
    start(10'h010, 2);
    set_address = 1'b0;
    check("t5b_lane2_beat0", 64'(address_out[2*ADDR_W +: ADDR_W]), 64'h2AA);
    wait_done("t5b");
    check("t5b_busy_cycles", 64'(busy_cnt), 64'd3);

    // 6: asynchronous reset in SYNC, then restart from zero bases.
    start(10'd1, 4);
    step();
    check("t6_in_sync", {62'd0, addr_valid, busy}, 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_address_out", address_out, 64'd0);
    check("t6_async_valid_busy_done", {61'd0, addr_valid, busy, done}, 64'd0);
    exp_q.delete();
    for (int l = 0; l < LANES; l++) mb[l] = '0;
    begin
      int d0;
      d0 = done_cnt;
      step();
      reset_n = 1'b1;
      step();
      step();
      check("t6_no_done_after_reset", 64'(done_cnt - d0), 64'd0);
    end
    busy_cnt = 0;
    start(10'd2, 3);
    check("t6_restart_beat0", address_out, 64'd0);
    wait_done("t6");
    check("t6_busy_cycles", 64'(busy_cnt), 64'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
